// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state type, default sizes and helpers for the
// run-time clock divider controller.
package clk_div_pkg;

  localparam int DIV_W_DEFAULT   = 8;
  localparam int DEF_DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // High time of the divided clock, ceil(n/2). Evaluated at 32 bits so an
  // all-ones ratio does not overflow when one is added.
  function automatic logic [31:0] half_up(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter with lookahead decode of the clock-enable
// strobe and the divided-clock level. Both outputs are registered from the
// value the counter takes on the same edge, so they line up with it.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,     // hold idle: counter 0, outputs low
  input  logic             i_load,      // start a fresh period using i_load_div
  input  logic [DIV_W-1:0] i_load_div,
  input  logic [DIV_W-1:0] i_div,       // ratio of the period now running
  output logic             o_wrap,      // counter is in the last cycle of its period
  output logic             o_ce,
  output logic             o_div_clk
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] div_eff;
  logic             ce_reg;
  logic             ce_next;
  logic             div_clk_reg;
  logic             div_clk_next;

  assign o_wrap    = (cnt_reg == i_div - DIV_W'(1));
  assign o_ce      = ce_reg;
  assign o_div_clk = div_clk_reg;

  // Next counter value and the strobe/level it implies for the next cycle.
  always_comb begin
    div_eff  = i_div;
    cnt_next = cnt_reg + DIV_W'(1);
    if (i_load) begin
      div_eff  = i_load_div;
      cnt_next = '0;
    end else if (o_wrap) begin
      cnt_next = '0;
    end
    ce_next      = (cnt_next == div_eff - DIV_W'(1));
    div_clk_next = (32'(cnt_next) < half_up(32'(div_eff)));
  end

  // Advance the counter and register the decoded outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      cnt_reg     <= '0;
      ce_reg      <= 1'b0;
      div_clk_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      ce_reg      <= ce_next;
      div_clk_reg <= div_clk_next;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for the system clock divider. Accepts
// ratio / run-state requests over a valid/ready port and applies them only
// at period boundaries so the divided clock never produces a runt pulse.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEFAULT,
  parameter int DEF_DIV = DEF_DIV_DEFAULT,
  parameter bit DEF_EN  = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic             i_cfg_en,
  input  logic [DIV_W-1:0] i_cfg_div,
  output logic             o_cfg_err,
  output logic             o_ce,
  output logic             o_div_clk,
  output logic             o_busy,
  output logic [DIV_W-1:0] o_cur_div
);

  state_t           state_reg;
  logic [DIV_W-1:0] cur_div_reg;
  logic [DIV_W-1:0] pend_div_reg;
  logic             pend_en_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             err_reg;

  logic             accept;
  logic             cfg_ok;
  logic             start_req;
  logic             core_clear;
  logic             core_load;
  logic [DIV_W-1:0] core_load_div;
  logic             core_wrap;

  assign accept    = i_cfg_valid && ready_reg;
  assign cfg_ok    = accept && (i_cfg_div != '0);
  assign start_req = cfg_ok && i_cfg_en;

  assign o_cfg_ready = ready_reg;
  assign o_busy      = busy_reg;
  assign o_cfg_err   = err_reg;
  assign o_cur_div   = cur_div_reg;

  // Steer the counter: idle while off, restart on start or on an applied change.
  always_comb begin
    core_clear    = 1'b0;
    core_load     = 1'b0;
    core_load_div = cur_div_reg;
    case (state_reg)
      OFF: begin
        if (start_req) begin
          core_load     = 1'b1;
          core_load_div = i_cfg_div;
        end else begin
          core_clear = 1'b1;
        end
      end
      PEND: begin
        if (core_wrap) begin
          if (pend_en_reg) begin
            core_load     = 1'b1;
            core_load_div = pend_div_reg;
          end else begin
            core_clear = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Controller FSM with handshake and held-request registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= DEF_EN ? RUN : OFF;
      cur_div_reg  <= DIV_W'(DEF_DIV);
      pend_div_reg <= '0;
      pend_en_reg  <= 1'b0;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      err_reg <= accept && (i_cfg_div == '0);
      case (state_reg)
        OFF: begin
          if (start_req) begin
            state_reg   <= RUN;
            cur_div_reg <= i_cfg_div;
          end
        end
        RUN: begin
          if (cfg_ok) begin
            state_reg    <= PEND;
            pend_en_reg  <= i_cfg_en;
            pend_div_reg <= i_cfg_div;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        PEND: begin
          if (core_wrap) begin
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            if (pend_en_reg) begin
              state_reg   <= RUN;
              cur_div_reg <= pend_div_reg;
            end else begin
              state_reg <= OFF;
            end
          end
        end
        default: state_reg <= OFF;
      endcase
    end
  end

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (core_clear),
    .i_load     (core_load),
    .i_load_div (core_load_div),
    .i_div      (cur_div_reg),
    .o_wrap     (core_wrap),
    .o_ce       (o_ce),
    .o_div_clk  (o_div_clk)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed scenarios plus randomized traffic, checked
// against a period-position reference model of the divider.
module tb_clk_div_ctrl;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_en = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             ce;
  logic             div_clk;
  logic             busy;
  logic [DIV_W-1:0] cur_div;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .DIV_W   (DIV_W),
    .DEF_DIV (4),
    .DEF_EN  (1'b1)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_en    (cfg_en),
    .i_cfg_div   (cfg_div),
    .o_cfg_err   (cfg_err),
    .o_ce        (ce),
    .o_div_clk   (div_clk),
    .o_busy      (busy),
    .o_cur_div   (cur_div)
  );

  // Reference model: running flag, ratio, position within the period,
  // and at most one held request.
  bit m_run, m_pend, m_pend_en, m_err, m_ce, m_dclk;
  int m_n, m_pos, m_pend_n;

  logic [12:0] obs;
  assign obs = {ce, div_clk, busy, cfg_ready, cfg_err, cur_div};

  function automatic logic [12:0] expv();
    return {m_ce, m_dclk, m_pend, !m_pend, m_err, 8'(m_n)};
  endfunction

  task automatic model_edge();
    bit was_run;
    bit acc;
    if (rst) begin
      m_run = 1'b1; m_n = 4; m_pos = 0; m_pend = 1'b0;
      m_err = 1'b0; m_ce = 1'b0; m_dclk = 1'b0;
      return;
    end
    was_run = m_run;
    acc     = cfg_valid && !m_pend;
    m_err   = acc && (cfg_div == 0);
    if (m_run) begin
      if (m_pos == m_n - 1) begin
        m_pos = 0;
        if (m_pend) begin
          m_pend = 1'b0;
          if (m_pend_en) m_n = m_pend_n;
          else m_run = 1'b0;
        end
      end else begin
        m_pos++;
      end
    end
    if (acc && cfg_div != 0) begin
      if (was_run) begin
        m_pend = 1'b1; m_pend_en = cfg_en; m_pend_n = int'(cfg_div);
      end else if (cfg_en) begin
        m_run = 1'b1; m_n = int'(cfg_div); m_pos = 0;
      end
    end
    m_ce   = m_run && (m_pos == m_n - 1);
    m_dclk = m_run && (m_pos < (m_n + 1) / 2);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Advance until the model is running with nothing held; want_pos >= 0
  // also requires that counter position, -2 requires the wrap position.
  task automatic wait_model(input int want_pos, input string what);
    int k = 0;
    while (!(m_run && !m_pend &&
             (want_pos == -1 || (want_pos == -2 && m_pos == m_n - 1) || m_pos == want_pos))
           && k < 600) begin
      step();
      k++;
    end
    checks++;
    if (k >= 600) begin
      errors++;
      $display("FAIL wait_%s: waited %0d cycles, required state never reached", what, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (obs !== expv()) begin
      errors++; $display("FAIL reset_state: got %h expected %h", obs, expv());
    end
    for (int c = 2; c <= 12; c++) begin
      step();
      checks++;
      if (ce !== (c % 4 == 0)) begin
        errors++; $display("FAIL reset_ce cycle %0d: got %b expected %b", c, ce, (c % 4 == 0));
      end
      if (c >= 5) begin
        checks++;
        if (div_clk !== (((c - 1) % 4) < 2)) begin
          errors++; $display("FAIL reset_divclk cycle %0d: got %b expected %b", c, div_clk, (((c - 1) % 4) < 2));
        end
      end
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL reset_run cycle %0d: got %h expected %h", c, obs, expv());
      end
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_ratio_change();
    int ces = 0;
    wait_model(1, "cnt1");
    cfg_valid = 1'b1; cfg_en = 1'b1; cfg_div = 8'd3;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL ratio_change cycle %0d: got %h expected %h", i, obs, expv());
      end
      step();
    end
    for (int i = 0; i < 9; i++) begin
      if (ce === 1'b1) ces++;
      step();
    end
    checks++;
    if (ces != 3 || cur_div !== 8'd3) begin
      errors++; $display("FAIL ratio_period: got %0d strobes div %0d expected 3 strobes div 3", ces, cur_div);
    end
    $display("test_ratio_change done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_zero_div();
    int errs_seen = 0;
    wait_model(-1, "run_zero");
    cfg_valid = 1'b1; cfg_en = 1'b1; cfg_div = 8'd0;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL zero_div cycle %0d: got %h expected %h", i, obs, expv());
      end
      if (cfg_err === 1'b1) errs_seen++;
      step();
    end
    checks++;
    if (errs_seen != 1 || cur_div !== 8'd3) begin
      errors++; $display("FAIL zero_div_pulse: got %0d err cycles div %0d expected 1 and 3", errs_seen, cur_div);
    end
    $display("test_zero_div done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_stop_start();
    int k = 0;
    wait_model(-1, "run_stop");
    cfg_valid = 1'b1; cfg_en = 1'b0; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    while (m_run && k < 40) begin
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL stop cycle %0d: got %h expected %h", k, obs, expv());
      end
      step();
      k++;
    end
    checks++;
    if (k >= 40) begin
      errors++; $display("FAIL stop_timeout: got %0d cycles expected stop within 40", k);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({ce, div_clk} !== 2'b00 || obs !== expv()) begin
        errors++; $display("FAIL stopped cycle %0d: got %h expected %h", i, obs, expv());
      end
      step();
    end
    cfg_valid = 1'b1; cfg_en = 1'b1; cfg_div = 8'd1;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({ce, div_clk} !== 2'b11 || obs !== expv()) begin
        errors++; $display("FAIL div1 cycle %0d: got %h expected %h", i, obs, expv());
      end
      step();
    end
    checks++;
    if (cur_div !== 8'd1) begin
      errors++; $display("FAIL div1_cur: got %0d expected 1", cur_div);
    end
    $display("test_stop_start done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_to_back();
    bit will_acc;
    int old_n, new_n, k;
    cfg_valid = 1'b1; cfg_en = 1'b1; cfg_div = 8'($urandom_range(2, 6));
    for (int i = 0; i < 40; i++) begin
      will_acc = !m_pend;
      step();
      checks++;
      if (obs !== expv() || cfg_ready !== ~busy) begin
        errors++; $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs, expv());
      end
      if (will_acc) cfg_div = 8'($urandom_range(2, 6));
    end
    cfg_valid = 1'b0;
    wait_model(-2, "wrap");
    old_n = m_n;
    new_n = (old_n == 2) ? 3 : 2;
    cfg_valid = 1'b1; cfg_div = 8'(new_n); cfg_en = 1'b1;
    step();
    cfg_valid = 1'b0;
    k = 0;
    while (cur_div === 8'(old_n) && k < 64) begin
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL wrap_req cycle %0d: got %h expected %h", k, obs, expv());
      end
      step();
      k++;
    end
    checks++;
    if (k != old_n || cur_div !== 8'(new_n)) begin
      errors++; $display("FAIL wrap_hold: got %0d cycles div %0d expected %0d cycles div %0d", k, cur_div, old_n, new_n);
    end
    $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_pending();
    wait_model(0, "pos0");
    cfg_valid = 1'b1; cfg_en = 1'b1; cfg_div = 8'd7;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL pend_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs !== {5'b00010, 8'd4}) begin
      errors++; $display("FAIL reset_pend: got %h expected %h", obs, {5'b00010, 8'd4});
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs !== expv() || cur_div === 8'd7) begin
        errors++; $display("FAIL after_reset cycle %0d: got %h expected %h", i, obs, expv());
      end
    end
    $display("test_reset_pending done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_en    = ($urandom_range(0, 3) != 0);
      r         = int'($urandom_range(0, 15));
      if (r == 0) cfg_div = 8'd0;
      else if (r == 15) cfg_div = 8'($urandom_range(200, 255));
      else cfg_div = 8'($urandom_range(1, 9));
      step();
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL random cycle %0d: got %h expected %h", i, obs, expv());
      end
    end
    rst = 1'b0; cfg_valid = 1'b0;
    $display("test_random done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_ratio_change();
    test_zero_div();
    test_stop_start();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
